// File: rtl/piso_pkg.sv
// Shared types and helpers for the PISO serializer slice.
package piso_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_e;

  // Bit counter must still be one bit wide for a single-bit frame.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_serializer_sync_enable_if.sv
// Load handshake and serial-side bundle for piso_serializer_sync_enable.
interface piso_serializer_sync_enable_if #(
  parameter int N = 8
);
  logic         shift_en;
  logic         load_valid;
  logic         load_ready;
  logic [N-1:0] load_data;
  logic         serial_out;
  logic         serial_valid;
  logic         frame_start;
  logic         busy;

  modport master (
    output shift_en, load_valid, load_data,
    input  load_ready, serial_out, serial_valid, frame_start, busy
  );

  modport slave (
    input  shift_en, load_valid, load_data,
    output load_ready, serial_out, serial_valid, frame_start, busy
  );
endinterface

// File: rtl/down_counter_sync_load.sv
// Down-counter: async reset, synchronous load (priority) and decrement enable.
module down_counter_sync_load #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         zero
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     count <= '0;
    else if (load) count <= load_val;
    else if (dec)  count <= count - W'(1);
  end

  assign zero = (count == '0);
endmodule

// File: rtl/piso_serializer_sync_enable.sv
// Parallel-in/serial-out transmitter, one bit per shift_en pulse.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits.
module piso_serializer_sync_enable
  import piso_pkg::*;
#(
  parameter int N         = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input logic clk,
  input logic reset,
  piso_serializer_sync_enable_if.slave bus
);
  localparam int CW = cnt_width(N);
  localparam logic [1:0] IDLE   = ST_IDLE;
  localparam logic [1:0] SHIFT  = ST_SHIFT;
  localparam logic [1:0] PARITY = ST_PARITY;

  logic [1:0]    state;
  logic [N-1:0]  sreg;
  logic [CW-1:0] cnt;
  logic          cnt_zero;
  logic          load_acc;
  logic          shift_acc;
  logic          out_bit;

  assign load_acc  = (state == IDLE) && bus.load_valid;
  assign shift_acc = (state == SHIFT) && bus.shift_en;

  down_counter_sync_load #(.W(CW)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (load_acc),
    .dec      (shift_acc && !cnt_zero),
    .load_val (CW'(N-1)),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sreg  <= '0;
    end else begin
      case (state)
        IDLE: if (bus.load_valid) begin
          sreg  <= bus.load_data;
          state <= SHIFT;
        end
        SHIFT: if (bus.shift_en) begin
          if (!cnt_zero) sreg <= LSB_FIRST ? (sreg >> 1) : (sreg << 1);
`ifdef PISO_PARITY_EN
          else           state <= PARITY;
`else
          else           state <= IDLE;
`endif
        end
`ifdef PISO_PARITY_EN
        PARITY: if (bus.shift_en) state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PISO_PARITY_EN
  logic par;

  // Parity is taken from the word as captured, not from the shifting copy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         par <= 1'b0;
    else if (load_acc) par <= ^bus.load_data;
  end
`endif

  assign out_bit = LSB_FIRST ? sreg[0] : sreg[N-1];

  always_comb begin
    bus.serial_out = 1'b0;
    case (state)
      SHIFT:   bus.serial_out = out_bit;
`ifdef PISO_PARITY_EN
      PARITY:  bus.serial_out = par;
`endif
      default: bus.serial_out = 1'b0;
    endcase
  end

  assign bus.load_ready   = (state == IDLE);
  assign bus.busy         = (state != IDLE);
  assign bus.serial_valid = (state != IDLE);
  assign bus.frame_start  = (state == SHIFT) && (cnt == CW'(N-1));
endmodule

// File: tb/tb_piso_serializer_sync_enable.sv
// Bench for piso_serializer_sync_enable: LSB-first, MSB-first and N=1 copies
// share one stimulus stream and are checked against a bit-queue frame model.
module tb_piso_serializer_sync_enable;
`ifdef PISO_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NN [3] = '{8, 8, 1};
  localparam bit LS [3] = '{1'b1, 1'b0, 1'b1};

  logic       clk;
  logic       reset;
  logic       lv;
  logic       sen;
  logic [7:0] ld;
  int         checks;
  int         errors;
  bit         mq [3][$];

  piso_serializer_sync_enable_if #(.N(8)) if0 ();
  piso_serializer_sync_enable_if #(.N(8)) if1 ();
  piso_serializer_sync_enable_if #(.N(1)) if2 ();

  assign if0.load_valid = lv;  assign if0.shift_en = sen;  assign if0.load_data = ld;
  assign if1.load_valid = lv;  assign if1.shift_en = sen;  assign if1.load_data = ld;
  assign if2.load_valid = lv;  assign if2.shift_en = sen;  assign if2.load_data = ld[0:0];

  piso_serializer_sync_enable #(.N(8), .LSB_FIRST(1'b1)) u_lsb (.clk(clk), .reset(reset), .bus(if0));
  piso_serializer_sync_enable #(.N(8), .LSB_FIRST(1'b0)) u_msb (.clk(clk), .reset(reset), .bus(if1));
  piso_serializer_sync_enable #(.N(1), .LSB_FIRST(1'b1)) u_one (.clk(clk), .reset(reset), .bus(if2));

  logic [2:0] so, sv, fs, bz, rdy;
  assign so  = {if2.serial_out,   if1.serial_out,   if0.serial_out};
  assign sv  = {if2.serial_valid, if1.serial_valid, if0.serial_valid};
  assign fs  = {if2.frame_start,  if1.frame_start,  if0.frame_start};
  assign bz  = {if2.busy,         if1.busy,         if0.busy};
  assign rdy = {if2.load_ready,   if1.load_ready,   if0.load_ready};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // A frame is simply the list of bits the line must carry, in wire order.
  task automatic model_load(input int d, input logic [7:0] w);
    bit p;
    p = 1'b0;
    for (int i = 0; i < NN[d]; i++) begin
      mq[d].push_back(w[LS[d] ? i : NN[d] - 1 - i]);
      p = p ^ w[i];
    end
    if (PB == 1) mq[d].push_back(p);
  endtask

  task automatic check_idle_consts(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s d%0d serial_out", tag, d), so[d], 1'b0);
      chk($sformatf("%s d%0d serial_valid", tag, d), sv[d], 1'b0);
      chk($sformatf("%s d%0d frame_start", tag, d), fs[d], 1'b0);
      chk($sformatf("%s d%0d busy", tag, d), bz[d], 1'b0);
      chk($sformatf("%s d%0d load_ready", tag, d), rdy[d], 1'b1);
    end
  endtask

  // Check outputs mid-cycle, then advance the model across the coming edge.
  task automatic step();
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      bit act;
      act = (mq[d].size() != 0);
      chk($sformatf("d%0d serial_valid", d), sv[d], act);
      chk($sformatf("d%0d busy", d), bz[d], act);
      chk($sformatf("d%0d load_ready", d), rdy[d], !act);
      chk($sformatf("d%0d serial_out", d), so[d], act ? mq[d][0] : 1'b0);
      chk($sformatf("d%0d frame_start", d), fs[d], mq[d].size() == NN[d] + PB);
    end
    for (int d = 0; d < 3; d++) begin
      if (mq[d].size() == 0) begin
        if (lv) model_load(d, ld);
      end else if (sen) begin
        void'(mq[d].pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [7:0] w, input logic s);
    ld  = w;
    lv  = 1'b1;
    sen = s;
    step();
    lv  = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    lv     = 1'b0;
    sen    = 1'b0;
    ld     = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_idle_consts("reset");
    reset = 1'b0;

    // Continuous shifting, two frames; shift_en also high on the load edge.
    load_word(8'hA5, 1'b1);
    repeat (9) step();
    load_word(8'h01, 1'b1);
    repeat (9) step();

    // One enable every 4 cycles; a mid-frame load of 0xFF must be ignored.
    sen = 1'b0;
    load_word(8'h3C, 1'b0);
    for (int i = 0; i < 40; i++) begin
      sen = (i % 4 == 3);
      if (i == 10) begin lv = 1'b1; ld = 8'hFF; end
      else         lv = 1'b0;
      step();
    end
    lv = 1'b0;
    sen = 1'b1;
    repeat (4) step();

    // Async reset between edges partway through 0x96.
    load_word(8'h96, 1'b1);
    repeat (4) step();
    #2 reset = 1'b1;
    #1 check_idle_consts("async_reset");
    for (int d = 0; d < 3; d++) mq[d].delete();
    reset = 1'b0;
    load_word(8'h0F, 1'b1);
    repeat (10) step();

    // Back-to-back with load_valid held: one idle cycle between frames.
    ld  = 8'h12;
    lv  = 1'b1;
    sen = 1'b1;
    step();
    ld  = 8'h34;
    repeat (22) step();
    lv  = 1'b0;
    repeat (3) step();

    // Random traffic.
    repeat (400) begin
      lv  = ($urandom_range(0, 3) == 0);
      sen = 1'($urandom_range(0, 1));
      ld  = 8'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/piso_serializer_sync_enable.md
Name: piso_serializer_sync_enable

Overview:
- Parallel-in/serial-out transmitter. Accepts an N-bit word over a valid/ready load handshake, then emits it one bit per shift-enable pulse.
- Used as the transmit end of serial links whose receive end captures bits into enabled registers.
- Sits between a parallel datapath, such as a register or FIFO output, and a serial line driver gated by a baud/strobe tick.

Parameters:
- N, 8, number of data bits per frame; N >= 1.
- LSB_FIRST, 1, 1 = bit 0 transmitted first; 0 = bit N-1 transmitted first.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- shift_en  input  1  synchronous enable; one pulse consumes the current serial bit.
- load_valid  input  1  load_data is valid.
- load_ready  output  1  block can accept a word this cycle.
- load_data  input  N  parallel word to transmit.
- serial_out  output  1  current serial bit.
- serial_valid  output  1  serial_out carries a frame bit.
- frame_start  output  1  high while the first bit of a frame is presented.
- busy  output  1  frame in progress.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset). Everything else is synchronous to the rising edge of clk.
- States: IDLE, SHIFT, PARITY (PARITY exists only with the optional feature).
- Reset (async, also mid-frame):
  - state = IDLE; shift register = 0; bit counter = 0.
  - serial_out = 0, serial_valid = 0, frame_start = 0, busy = 0, load_ready = 1.
  - Any partial frame is abandoned; there is no resume.
- IDLE:
  - load_ready = 1.
  - On an edge with load_valid = 1: capture load_data, set counter = N-1, go to SHIFT.
  - shift_en is ignored in IDLE.
- SHIFT:
  - load_ready = 0; busy = 1; serial_valid = 1.
  - serial_out = shift_reg[0] if LSB_FIRST, otherwise shift_reg[N-1]. It is combinational from the register, so it is stable until consumed.
  - frame_start = 1 when counter == N-1 and the first bit has not yet been consumed.
  - Edge with shift_en = 1 and counter != 0: shift toward the output end (zero fill), counter - 1.
  - Edge with shift_en = 1 and counter == 0: go to IDLE, or to PARITY if the optional feature is enabled.
  - shift_en = 0: hold all state; the bit remains presented indefinitely.
- Latency:
  - Load accepted at edge k: first bit is valid after edge k.
  - With shift_en tied high, the last data bit is presented in cycle k+N-1 and load_ready returns after edge k+N.
  - The earliest next load is edge k+N+1, giving exactly one idle cycle between frames.
- Boundaries:
  - load_valid and load_data are ignored outside IDLE; changing load_data mid-frame has no effect.
  - N = 1: counter width is max(1, clog2(N)); the frame is a single bit.
  - load_valid and shift_en asserted on the same IDLE edge: the load occurs. That shift_en pulse is not consumed against the new word.
  - In IDLE, serial_out is forced to 0.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of the captured word, computed at load) follows the last data bit.
  - In PARITY: serial_valid = 1, serial_out = parity bit. The next shift_en edge goes to IDLE.
  - Frame length is N+1 enables.
- Undefined:
  - The PARITY state and parity register are absent; the frame is exactly N enables.
  - All other timing is unchanged.

Decomposition:
- Shared package piso_pkg:
  - State enum typedef (IDLE, SHIFT, PARITY).
  - localparam function for counter width, max(1, clog2(N)).
- One natural sub-module: down_counter_sync_load. It is a parameterised down-counter with async reset, synchronous load, and synchronous decrement enable, reused for the bit count.
- Shift register and FSM stay in the top module.

Test Plan:
- Reset, then N=8, LSB_FIRST=1, shift_en=1: load 0xA5 -> serial_out 1,0,1,0,0,1,0,1 on consecutive cycles; frame_start only on the first bit; load_ready high again after 8 bits.
- LSB_FIRST=0: load 0xA5 -> serial_out 1,0,1,0,0,1,0,1 (MSB first, bit 7 down to bit 0). Follow with 0x01 -> 0,0,0,0,0,0,0,1.
- shift_en pulsed every 4th cycle: load 0x3C -> each bit held 4 cycles; serial_valid continuous for 32 cycles; load_valid=1 with 0xFF mid-frame ignored.
- Async reset asserted between edges after bit 3 of 0x96 -> all outputs 0 immediately; after release, load 0x0F transmits cleanly.
- Back-to-back load_valid held high with 0x12 then 0x34 -> exactly one idle cycle (serial_valid=0, load_ready=1) between frames.
- PISO_PARITY_EN defined: load 0x07 -> 8 data bits then parity 1; load 0xA5 -> parity 0; frame length 9 enables.
